// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encodings and width helpers for seq_divider
package seq_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter width; a 1-bit divider still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// rtl/seq_divider_addsub.sv - parameterised adder/subtractor, ripple or carry-lookahead
//
// Ports:
//   a, b    operands, C_WIDTH bits
//   sub     1 = a - b (two's complement), 0 = a + b
//   result  C_WIDTH-bit sum/difference (carry out is not produced)
module seq_divider_addsub #(
    parameter int C_WIDTH = 16,
    parameter int USE_CLA = 1
) (
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               sub,
    output logic [C_WIDTH-1:0] result
);

    logic [C_WIDTH-1:0] bx;
    logic [C_WIDTH-1:0] p;
    logic [C_WIDTH-1:0] c;

    // Subtraction is a + ~b + 1: invert b and feed sub in as carry-in.
    assign bx     = b ^ {C_WIDTH{sub}};
    assign p      = a ^ bx;
    assign result = p ^ c;

    if (USE_CLA != 0) begin : g_cla
        logic term;
        logic ci;

        // Each carry is a flat sum of products of generate/propagate terms,
        // so no carry depends on another carry.
        always_comb begin
            c    = '0;
            term = 1'b0;
            ci   = 1'b0;
            c[0] = sub;
            for (int i = 1; i < C_WIDTH; i++) begin
                term = sub;
                for (int j = 0; j < i; j++) begin
                    term = term & p[j];
                end
                ci = term;
                for (int j = 0; j < i; j++) begin
                    term = a[j] & bx[j];
                    for (int k = j + 1; k < i; k++) begin
                        term = term & p[k];
                    end
                    ci = ci | term;
                end
                c[i] = ci;
            end
        end
    end else begin : g_ripple
        always_comb begin
            c    = '0;
            c[0] = sub;
            for (int i = 1; i < C_WIDTH; i++) begin
                c[i] = (a[i-1] & bx[i-1]) | (p[i-1] & c[i-1]);
            end
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring unsigned divider, one quotient bit per clock
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   start        request, accepted only while ready=1
//   dividend     numerator, sampled on accept
//   divisor      denominator, sampled on accept
//   ready        high in IDLE
//   valid        one-cycle pulse when results update
//   quotient     result quotient, held until next valid
//   remainder    result remainder, held until next valid
//   div_by_zero  flags the held result as a divide by zero
module seq_divider #(
    parameter int C_WIDTH = 16,
    parameter int USE_CLA = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [C_WIDTH-1:0] dividend,
    input  logic [C_WIDTH-1:0] divisor,
    output logic               ready,
    output logic               valid,
    output logic [C_WIDTH-1:0] quotient,
    output logic [C_WIDTH-1:0] remainder,
    output logic               div_by_zero
);

    import seq_divider_pkg::*;

    localparam int CW = cnt_width(C_WIDTH);

    state_t state;
    state_t next_state;

    // d_reg holds the unconsumed dividend bits at the top and collects
    // quotient bits at the bottom; after C_WIDTH shifts it is the quotient.
    logic [C_WIDTH-1:0] d_reg;
    logic [C_WIDTH-1:0] v_reg;
    logic [C_WIDTH-1:0] r_reg;
    logic [CW-1:0]      cnt;

    logic [C_WIDTH:0]   r_shift;
    logic [C_WIDTH:0]   diff;
    logic               q_bit;
    logic [C_WIDTH-1:0] r_next;
    logic [C_WIDTH-1:0] d_next;

    // Partial remainder is always below the divisor, so it fits C_WIDTH bits;
    // only the shifted trial value needs the extra bit.
    assign r_shift = {r_reg, d_reg[C_WIDTH-1]};

    seq_divider_addsub #(
        .C_WIDTH (C_WIDTH + 1),
        .USE_CLA (USE_CLA)
    ) u_sub (
        .a      (r_shift),
        .b      ({1'b0, v_reg}),
        .sub    (1'b1),
        .result (diff)
    );

    assign q_bit  = ~diff[C_WIDTH];
    assign r_next = q_bit ? diff[C_WIDTH-1:0] : r_shift[C_WIDTH-1:0];
    assign d_next = (d_reg << 1) | C_WIDTH'(q_bit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        valid      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == '0) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                valid      = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_reg       <= '0;
            v_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            d_reg <= dividend;
                            v_reg <= divisor;
                            r_reg <= '0;
                            cnt   <= CW'(C_WIDTH - 1);
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    d_reg <= d_next;
                    r_reg <= r_next;
                    cnt   <= cnt - 1'b1;
                    // Publish on the edge entering DONE so results line up with valid.
                    if (cnt == '0) begin
                        quotient    <= d_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring unsigned divider, one quotient bit per clock.
- Inverse-direction companion to the combinational adder/subtractor datapath: repeated conditional subtraction instead of addition.
- Serves synthesizer control paths needing a ratio (phase increment, envelope step = range / time) where latency is acceptable and a combinational divider is too large.
- Start/valid handshake toward a single requester.

Parameters:
- C_WIDTH, 16, width of dividend, divisor, quotient and remainder.
- USE_CLA, 1, passed to the subtractor instance: 1 = carry-lookahead, 0 = ripple.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request; accepted only when ready=1.
- dividend  input  C_WIDTH  unsigned numerator; sampled with an accepted start.
- divisor  input  C_WIDTH  unsigned denominator; sampled with an accepted start.
- ready  output  1  high in IDLE only.
- valid  output  1  one-cycle pulse when results are updated.
- quotient  output  C_WIDTH  result quotient; held until the next valid.
- remainder  output  C_WIDTH  result remainder; held until the next valid.
- div_by_zero  output  1  qualifies the current quotient/remainder; held with them.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; ready=1; valid=0; quotient=0; remainder=0; div_by_zero=0.
  - Internal registers cleared.
  - Reset mid-operation aborts the division with no valid pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - start=1 with divisor!=0: latch dividend into shift register D, divisor into V, partial remainder R (C_WIDTH+1 bits) = 0, bit counter = C_WIDTH-1; go to CALC.
  - start=1 with divisor=0: go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC (one iteration per cycle, C_WIDTH cycles):
  - T = {R[C_WIDTH-1:0], D[C_WIDTH-1]}.
  - Diff = T - {0,V}, computed by the subtractor at width C_WIDTH+1, sub=1.
  - Diff bit C_WIDTH = 0 (non-negative): R=Diff, shift 1 into the quotient LSB.
  - Otherwise: R=T, shift 0 into the quotient LSB.
  - D shifts left by one each cycle.
  - Counter decrements each cycle; on the cycle where counter=0, go to DONE.
- DONE (one cycle):
  - valid=1, ready=0.
  - quotient/remainder/div_by_zero registers updated on the edge entering DONE, so they are visible together with valid.
  - div_by_zero=0 for normal results.
  - Next state IDLE.
- Latency:
  - Normal: valid is high in the (C_WIDTH+1)th cycle after the start-accept edge.
  - Divide by zero: valid is high in the cycle immediately after accept.
  - Throughput: one division per C_WIDTH+2 cycles.
- start while ready=0 is ignored, with no queueing; inputs may change freely during CALC.
- start held high continuously: a new division is accepted on each return to IDLE.
- Width rules:
  - R is C_WIDTH+1 bits to hold the pre-subtract shifted value.
  - Final remainder = R[C_WIDTH-1:0], always < divisor.
  - quotient*divisor + remainder = dividend exactly (no overflow is possible for unsigned operands).
- Edge cases with no special path:
  - dividend=0 gives quotient=0, remainder=0.
  - divisor=1 gives quotient=dividend.
  - dividend<divisor gives quotient=0, remainder=dividend.

Decomposition:
- Shared constants include file:
  - state encodings S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2.
  - counter width derived as clog2(C_WIDTH).
- One sub-module: the existing subtractor, instantiated at C_WIDTH+1 width with USE_CLA forwarded and sub tied to 1.
- FSM, shift registers and counter stay in seq_divider.

Test Plan:
- C_WIDTH=8, dividend=100, divisor=7, start one cycle -> after 9 cycles valid=1 for exactly one cycle, quotient=14, remainder=2, div_by_zero=0; ready returns to 1 the next cycle.
- C_WIDTH=8, 255/1 -> quotient=255, remainder=0; then 5/9 -> quotient=0, remainder=5; then 0/3 -> quotient=0, remainder=0.
- C_WIDTH=8, 77/0 -> valid in the very next cycle, quotient=8'hFF, remainder=77, div_by_zero=1; the following 10/3 clears the flag, giving 3 r 1.
- Start 200/13 then pulse start with 9/2 during CALC -> second request ignored, result 15 r 5, only one valid pulse.
- Start 200/13, drive reset=0 for one edge at cycle 4 of CALC -> no valid, all outputs 0, ready=1; a new 50/6 then gives 8 r 2.
- C_WIDTH=4, both USE_CLA=1 and USE_CLA=0: exhaustive sweep of all 16x16 operand pairs -> every result matches the reference quotient/remainder, div_by_zero only when divisor=0.
